// File: rtl/sao_eo_apply_hor.sv
// Horizontal SAO edge-offset apply stage.
// Keeps a left/centre/right window over one row of samples, classifies the
// centre against its horizontal neighbours, adds the category offset and clips.
//
// state | meaning
// EMPTY | no sample held, waiting for the first sample of a row
// HELD  | centre sample held, waiting for its right neighbour
// FLUSH | row ended, last sample waits for the output register
module sao_eo_apply_hor #(
  parameter int BIT_DEPTH = 8,
  parameter int OFFSET_W  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ofs_load_i,
  input  logic [4*OFFSET_W-1:0]   ofs_in_i,
  input  logic                    sao_en_in_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [BIT_DEPTH-1:0]    in_pix_i,
  input  logic                    in_sol_i,
  input  logic                    in_eol_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [BIT_DEPTH-1:0]    out_pix_o,
  output logic                    out_sol_o,
  output logic                    out_eol_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_HELD, ST_FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [4*OFFSET_W-1:0]   ofs_q;
  logic                    sao_en_q;
  logic [BIT_DEPTH-1:0]    l_q, m_q;
  logic                    l_vld_q;
  logic                    first_pend_q;
  logic                    err_q;
  logic                    out_valid_q, out_sol_q, out_eol_q;
  logic [BIT_DEPTH-1:0]    out_pix_q;

  logic                    out_free, in_fire;
  logic                    start_row, shift, flush, proto_err;

  logic                    gt_l, lt_l, gt_r, lt_r;
  logic [2:0]              edge_sum;
  logic [OFFSET_W-1:0]     ofs_sel;
  logic signed [BIT_DEPTH+1:0] sum_wide;
  logic [BIT_DEPTH-1:0]    clipped, filt_pix;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    if (start_row || shift) state_d = in_eol_i ? ST_FLUSH : ST_HELD;
    if (flush)              state_d = ST_EMPTY;
  end

  // FSM outputs: handshake and per-cycle actions
  always_comb begin
    out_free   = !out_valid_q || out_ready_i;
    in_ready_o = (state_q != ST_FLUSH) && out_free;
    in_fire    = in_valid_i && in_ready_o;
    start_row  = 1'b0;
    shift      = 1'b0;
    flush      = 1'b0;
    proto_err  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          start_row = 1'b1;
          proto_err = !in_sol_i;
        end
      end
      ST_HELD: begin
        if (in_fire) begin
          if (in_sol_i) begin
            // a new row started before the old one ended: drop the held centre
            start_row = 1'b1;
            proto_err = 1'b1;
          end else begin
            shift = 1'b1;
          end
        end
      end
      ST_FLUSH: flush = out_free;
      default: ;
    endcase
  end

  // Edge classification and offset application for the held centre sample
  always_comb begin
    gt_l = m_q > l_q;
    lt_l = m_q < l_q;
    gt_r = m_q > in_pix_i;
    lt_r = m_q < in_pix_i;
    // 3-bit two's complement sum of the two neighbour signs (-2..+2)
    edge_sum = {2'b00, gt_l} - {2'b00, lt_l} + {2'b00, gt_r} - {2'b00, lt_r};
    case (edge_sum)
      3'b110:  ofs_sel = ofs_q[OFFSET_W-1:0];
      3'b111:  ofs_sel = ofs_q[2*OFFSET_W-1:OFFSET_W];
      3'b001:  ofs_sel = ofs_q[3*OFFSET_W-1:2*OFFSET_W];
      3'b010:  ofs_sel = ofs_q[4*OFFSET_W-1:3*OFFSET_W];
      default: ofs_sel = '0;
    endcase
    sum_wide = $signed({2'b00, m_q})
             + $signed({{(BIT_DEPTH+2-OFFSET_W){ofs_sel[OFFSET_W-1]}}, ofs_sel});
    if (sum_wide[BIT_DEPTH+1])    clipped = '0;
    else if (sum_wide[BIT_DEPTH]) clipped = '1;
    else                          clipped = sum_wide[BIT_DEPTH-1:0];
    // the first sample of a row has no left neighbour and passes through
    filt_pix = (sao_en_q && l_vld_q) ? clipped : m_q;
  end

  // Window, configuration and sticky error registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ofs_q        <= '0;
      sao_en_q     <= 1'b0;
      l_q          <= '0;
      m_q          <= '0;
      l_vld_q      <= 1'b0;
      first_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (ofs_load_i) begin
        ofs_q    <= ofs_in_i;
        sao_en_q <= sao_en_in_i;
      end
      if (proto_err) err_q <= 1'b1;
      if (start_row) begin
        m_q          <= in_pix_i;
        l_vld_q      <= 1'b0;
        first_pend_q <= 1'b1;
      end
      if (shift) begin
        l_q          <= m_q;
        l_vld_q      <= 1'b1;
        m_q          <= in_pix_i;
        first_pend_q <= 1'b0;
      end
      if (flush) begin
        l_vld_q      <= 1'b0;
        first_pend_q <= 1'b0;
      end
    end
  end

  // Output register: loads on shift or flush, holds while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else if (shift) begin
      out_valid_q <= 1'b1;
      out_pix_q   <= filt_pix;
      out_sol_q   <= first_pend_q;
      out_eol_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b1;
      out_pix_q   <= m_q;
      out_sol_q   <= first_pend_q;
      out_eol_q   <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_pix_o   = out_pix_q;
  assign out_sol_o   = out_sol_q;
  assign out_eol_o   = out_eol_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sao_eo_apply_hor.sv
// Directed testbench for sao_eo_apply_hor.
module tb_sao_eo_apply_hor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ofs_load = 1'b0;
  logic [15:0] ofs_in = '0;
  logic        sao_en_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pix = '0;
  logic        in_sol = 1'b0;
  logic        in_eol = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_pix;
  logic        out_sol, out_eol, err;

  int tests = 0;
  int fails = 0;
  logic [9:0] q_out[$];

  sao_eo_apply_hor #(.BIT_DEPTH(8), .OFFSET_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .ofs_load_i(ofs_load), .ofs_in_i(ofs_in),
    .sao_en_in_i(sao_en_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pix_i(in_pix), .in_sol_i(in_sol), .in_eol_i(in_eol),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pix_o(out_pix),
    .out_sol_o(out_sol), .out_eol_o(out_eol), .err_o(err)
  );

  always #5 clk = ~clk;

  // record every output transfer as {sol, eol, pix}
  always @(negedge clk)
    if (!rst && out_valid && out_ready) q_out.push_back({out_sol, out_eol, out_pix});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] p, input logic s, input logic e);
    int n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; in_pix = p; in_sol = s; in_eol = e;
    do begin
      @(negedge clk); acc = in_ready;
      tick(); n++;
    end while (!acc && n < 50);
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL push_timeout pix=%0d accepted=%0b required=1", p, acc);
    end
    in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
  endtask

  task automatic send_row(input int n, input logic [7:0] p0, p1, p2, p3);
    logic [7:0] pp [4];
    pp = '{p0, p1, p2, p3};
    for (int i = 0; i < n; i++) push(pp[i], i == 0, i == n - 1);
  endtask

  task automatic load_ofs(input logic [15:0] o, input logic en);
    ofs_load = 1'b1; ofs_in = o; sao_en_in = en;
    tick();
    ofs_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    tests++;
    if ({out_valid, err, in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reset_state got valid/err/ready=%b required 001", {out_valid, err, in_ready});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [9:0] exp [4];
    exp = '{{2'b10, 8'd10}, {2'b00, 8'd8}, {2'b00, 8'd9}, {2'b01, 8'd10}};
    q_out.delete();
    load_ofs({4'hD, 4'hF, 4'h1, 4'h3}, 1'b1);
    send_row(4, 8'd10, 8'd5, 8'd10, 8'd10);
    repeat (5) tick();
    tests++;
    if (q_out.size() != 4) begin
      fails++; $display("FAIL basic_count got %0d required 4", q_out.size());
    end
    for (int i = 0; i < 4 && i < q_out.size(); i++) begin
      tests++;
      if (q_out[i] !== exp[i]) begin
        fails++; $display("FAIL basic_out[%0d] got %h required %h", i, q_out[i], exp[i]);
      end
    end
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL basic_err got %b required 0", err);
    end
  endtask

  task automatic test_clip();
    logic [9:0] exp [6];
    exp = '{{2'b10, 8'd255}, {2'b00, 8'd255}, {2'b01, 8'd255},
            {2'b10, 8'd0},   {2'b00, 8'd0},   {2'b01, 8'd0}};
    q_out.delete();
    load_ofs({4'h8, 4'h0, 4'h0, 4'h7}, 1'b1);
    send_row(3, 8'd255, 8'd250, 8'd255, 8'd0);
    send_row(3, 8'd0, 8'd3, 8'd0, 8'd0);
    repeat (5) tick();
    tests++;
    if (q_out.size() != 6) begin
      fails++; $display("FAIL clip_count got %0d required 6", q_out.size());
    end
    for (int i = 0; i < 6 && i < q_out.size(); i++) begin
      tests++;
      if (q_out[i] !== exp[i]) begin
        fails++; $display("FAIL clip_out[%0d] got %h required %h", i, q_out[i], exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [9:0] exp [4];
    exp = '{{2'b10, 8'd10}, {2'b00, 8'd8}, {2'b00, 8'd9}, {2'b01, 8'd10}};
    q_out.delete();
    load_ofs({4'hD, 4'hF, 4'h1, 4'h3}, 1'b1);
    fork
      send_row(4, 8'd10, 8'd5, 8'd10, 8'd10);
      begin
        int n = 0;
        logic [9:0] held;
        while (!out_valid && n < 40) begin tick(); n++; end
        tests++;
        if (!out_valid) begin
          fails++; $display("FAIL stall_first_out got valid=%b required 1", out_valid);
        end
        out_ready = 1'b0;
        held = {out_sol, out_eol, out_pix};
        repeat (5) begin
          @(negedge clk);
          tests++;
          if ({out_valid, in_ready, out_sol, out_eol, out_pix} !== {2'b10, held}) begin
            fails++;
            $display("FAIL stall_hold got valid/ready/out=%b/%b/%h required 1/0/%h",
                     out_valid, in_ready, {out_sol, out_eol, out_pix}, held);
          end
        end
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (5) tick();
    tests++;
    if (q_out.size() != 4) begin
      fails++; $display("FAIL stall_count got %0d required 4", q_out.size());
    end
    for (int i = 0; i < 4 && i < q_out.size(); i++) begin
      tests++;
      if (q_out[i] !== exp[i]) begin
        fails++; $display("FAIL stall_out[%0d] got %h required %h", i, q_out[i], exp[i]);
      end
    end
  endtask

  task automatic test_single();
    q_out.delete();
    send_row(1, 8'd77, 8'd0, 8'd0, 8'd0);
    repeat (4) tick();
    tests++;
    if (q_out.size() != 1 || q_out[0] !== {2'b11, 8'd77}) begin
      fails++;
      $display("FAIL single_out got n=%0d first=%h required n=1 first=%h",
               q_out.size(), (q_out.size() > 0) ? q_out[0] : 10'h0, {2'b11, 8'd77});
    end
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL single_idle got valid/ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_passthrough();
    logic [9:0] exp [4];
    exp = '{{2'b10, 8'd10}, {2'b00, 8'd5}, {2'b00, 8'd10}, {2'b01, 8'd10}};
    q_out.delete();
    load_ofs({4'hD, 4'hF, 4'h1, 4'h3}, 1'b0);
    send_row(4, 8'd10, 8'd5, 8'd10, 8'd10);
    repeat (5) tick();
    tests++;
    if (q_out.size() != 4) begin
      fails++; $display("FAIL pass_count got %0d required 4", q_out.size());
    end
    for (int i = 0; i < 4 && i < q_out.size(); i++) begin
      tests++;
      if (q_out[i] !== exp[i]) begin
        fails++; $display("FAIL pass_out[%0d] got %h required %h", i, q_out[i], exp[i]);
      end
    end
  endtask

  task automatic test_err_sol();
    logic [9:0] exp [3];
    exp = '{{2'b10, 8'd10}, {2'b10, 8'd20}, {2'b01, 8'd30}};
    q_out.delete();
    load_ofs({4'hD, 4'hF, 4'h1, 4'h3}, 1'b1);
    push(8'd10, 1'b1, 1'b0);
    push(8'd5,  1'b0, 1'b0);
    push(8'd20, 1'b1, 1'b0);
    push(8'd30, 1'b0, 1'b1);
    repeat (5) tick();
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL err_set got %b required 1", err);
    end
    tests++;
    if (q_out.size() != 3) begin
      fails++; $display("FAIL err_count got %0d required 3", q_out.size());
    end
    for (int i = 0; i < 3 && i < q_out.size(); i++) begin
      tests++;
      if (q_out[i] !== exp[i]) begin
        fails++; $display("FAIL err_out[%0d] got %h required %h", i, q_out[i], exp[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    push(8'd10, 1'b1, 1'b0);
    push(8'd5,  1'b0, 1'b0);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL rst_pending got valid=%b required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, err} !== 2'b00) begin
      fails++; $display("FAIL rst_mid got valid/err=%b required 00", {out_valid, err});
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    q_out.delete();
    send_row(1, 8'd77, 8'd0, 8'd0, 8'd0);
    repeat (4) tick();
    tests++;
    if (q_out.size() != 1 || q_out[0] !== {2'b11, 8'd77}) begin
      fails++;
      $display("FAIL rst_after got n=%0d first=%h required n=1 first=%h",
               q_out.size(), (q_out.size() > 0) ? q_out[0] : 10'h0, {2'b11, 8'd77});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_stall();
    test_single();
    test_passthrough();
    test_err_sol();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
